// File: rtl/qmath_pkg.sv
// Shared definitions for the sign-magnitude Q-format math units (multiplier, divider).
package qmath_pkg;
  localparam int QM_N     = 32;
  localparam int QM_Q     = 15;
  localparam int QM_ACC_W = 2 * (QM_N - 1);
  localparam int QM_CNT_W = $clog2(QM_N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} qm_state_e;
endpackage

// File: rtl/qmult_seq_if.sv
// Start/complete handshake bundle for the sequential Q multiplier.
interface qmult_seq_if
  import qmath_pkg::*;
#(
  parameter int N = QM_N
);
  logic         start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic [N-1:0] product_out;
  logic         complete;
  logic         overflow;

  modport master (output start, multiplicand, multiplier,
                  input  product_out, complete, overflow);
  modport slave  (input  start, multiplicand, multiplier,
                  output product_out, complete, overflow);
endinterface

// File: rtl/qmult_seq.sv
// Shift-and-add sign-magnitude Q multiplier: one multiplier bit per clock, N-1 cycles per result.
module qmult_seq
  import qmath_pkg::*;
#(
  parameter int N = QM_N,
  parameter int Q = QM_Q
) (
  input  logic       clk,
  input  logic       reset,
  qmult_seq_if.slave bus
);
  localparam int ACC_W = 2 * (N - 1);
  localparam int CNT_W = $clog2(N);

  qm_state_e          state_q, state_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [N-2:0]       mplier_q, mplier_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [N-1:0]       product_q, product_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_sum;
  logic [N-2:0]       mag;
  logic               hi_nz;

  // The final cycle's add must be included in the result, so format from acc_sum, not acc_q.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign hi_nz   = |acc_sum[ACC_W-1:N-1+Q];
  assign mag     = hi_nz ? '1 : acc_sum[N-2+Q:Q];

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = BUSY;
          mcand_d  = ACC_W'(bus.multiplicand[N-2:0]);
          mplier_d = bus.multiplier[N-2:0];
          sign_d   = bus.multiplicand[N-1] ^ bus.multiplier[N-1];
          acc_d    = '0;
          cnt_d    = CNT_W'(N - 2);
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d   = IDLE;
          // Zero magnitude never carries a sign.
          product_d = {sign_q & (|mag), mag};
          ovf_d     = hi_nz;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.complete    = (state_q == IDLE);
  assign bus.product_out = product_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_qmult_seq.sv
// Scoreboard bench for qmult_seq: acceptances push reference results, a monitor checks completions.
module tb_qmult_seq;
  localparam int N = 32;
  localparam int Q = 15;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  qmult_seq_if #(.N(N)) bus ();
  qmult_seq #(.N(N), .Q(Q)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [N-1:0] prod;
    logic         ovf;
  } exp_t;

  exp_t   exp_q[$];
  logic   aborted = 1'b0;
  logic   held_mode = 1'b0;
  logic   have_prev = 1'b0;
  int     prev_acc = 0;
  logic   prev_c = 1'b1;
  int     busy_cnt = 0;
  logic [N-1:0] last_prod = '0;
  logic         last_ovf  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer product of magnitudes, then Q rescale with saturation.
  function automatic exp_t ref_mult(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    logic [2*N-1:0] m;
    exp_t r;
    p = (2*N)'(a[N-2:0]) * (2*N)'(b[N-2:0]);
    m = p >> Q;
    r.ovf = (p >> (N - 1 + Q)) != 0;
    if (r.ovf) m = (2*N)'({(N-1){1'b1}});
    r.prod = {(a[N-1] ^ b[N-1]) && (m != 0), m[N-2:0]};
    return r;
  endfunction

  // Issue side: an edge accepts when complete is high, start high and reset low.
  always @(negedge clk) begin
    if (bus.complete === 1'b1 && bus.start === 1'b1 && reset === 1'b0) begin
      exp_q.push_back(ref_mult(bus.multiplicand, bus.multiplier));
      if (held_mode && have_prev) check("accept_spacing", 64'(cyc - prev_acc), 64'(N));
      prev_acc  = cyc;
      have_prev = 1'b1;
    end
  end

  // Monitor side.
  always @(negedge clk) begin
    exp_t e;
    if (bus.complete === 1'b0 && prev_c === 1'b1) begin
      busy_cnt = 0;
      check("hold_while_busy", 64'(bus.product_out), 64'(last_prod));
    end
    if (bus.complete === 1'b0) busy_cnt++;
    if (bus.complete === 1'b1 && prev_c === 1'b0) begin
      if (aborted) begin
        check("abort_product", 64'(bus.product_out), 64'h0);
        check("abort_overflow", 64'(bus.overflow), 64'h0);
        aborted   = 1'b0;
        last_prod = '0;
        last_ovf  = 1'b0;
      end else if (exp_q.size() == 0) begin
        check("unexpected_completion", 64'(exp_q.size()), 64'h1);
      end else begin
        e = exp_q.pop_front();
        check("product", 64'(bus.product_out), 64'(e.prod));
        check("overflow", 64'(bus.overflow), 64'(e.ovf));
        check("busy_cycles", 64'(busy_cnt), 64'(N - 1));
        last_prod = e.prod;
        last_ovf  = e.ovf;
      end
    end
    prev_c = bus.complete;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.complete !== 1'b1 || exp_q.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("idle_timeout", 64'(t), 64'h0);
    tick();
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    wait_idle();
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] v;
    v = N'($urandom) >> $urandom_range(1, 22);
    v[N-1] = 1'($urandom);
    return v;
  endfunction

  logic [N-1:0] dir_a [9] = '{32'h0000C000, 32'h8000C000, 32'h8000C000, 32'h00004000,
                              32'h80000001, 32'h40000000, 32'h00008000, 32'h00000000,
                              32'h7FFFFFFF};
  logic [N-1:0] dir_b [9] = '{32'h00010000, 32'h00010000, 32'h8000C000, 32'h00004000,
                              32'h00000001, 32'h00010000, 32'h00008000, 32'h80008000,
                              32'h00000001};

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    tick(3);
    check("reset_complete", 64'(bus.complete), 64'h1);
    check("reset_product", 64'(bus.product_out), 64'h0);
    check("reset_overflow", 64'(bus.overflow), 64'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) issue(dir_a[i], dir_b[i]);
    wait_idle();
    check("held_after_done", 64'(bus.product_out), 64'(last_prod));

    // Mid-operation start with different operands must be ignored.
    issue(32'h00018000, 32'h00014000);
    tick(5);
    bus.multiplicand = 32'h7FFFFFFF;
    bus.multiplier   = 32'h7FFFFFFF;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    wait_idle();

    // Start held high: back-to-back acceptances every N cycles.
    held_mode = 1'b1;
    have_prev = 1'b0;
    bus.multiplicand = 32'h00006000;
    bus.multiplier   = 32'h8000A000;
    bus.start        = 1'b1;
    tick(3 * N + 2);
    bus.start = 1'b0;
    held_mode = 1'b0;
    wait_idle();

    // Reset during BUSY cycle 10.
    issue(32'h0001C000, 32'h00012000);
    tick(9);
    aborted = 1'b1;
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_complete", 64'(bus.complete), 64'h1);
    issue(32'h00008000, 32'h00008000);
    wait_idle();

    // Start on the same edge as reset is ignored.
    bus.multiplicand = 32'h00010000;
    bus.multiplier   = 32'h00010000;
    bus.start = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    last_prod = '0;
    check("reset_start_complete", 64'(bus.complete), 64'h1);
    check("reset_start_product", 64'(bus.product_out), 64'h0);

    for (int i = 0; i < 30; i++) issue(rnd_op(), rnd_op());
    wait_idle();
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/qmult_seq.md
# qmult_seq

Sequential sign-magnitude fixed-point multiplier that complements the team's iterative Q-format divider: same number format, same start/complete handshake, one multiplier bit processed per clock. It sits beside the divider in the fixed-point math datapath and lets control logic scale values up without a wide combinational multiplier.

## Interface
- `N`, 32, total word width: bit N-1 is the sign, bits N-2:0 are the magnitude.
- `Q`, 15, number of fractional bits in the magnitude.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a multiply; honoured only while `complete`=1.
- `multiplicand` input N: sign-magnitude Q operand A, sampled on the accepting edge.
- `multiplier` input N: sign-magnitude Q operand B, sampled on the accepting edge.
- `product_out` output N: sign-magnitude Q result; reset value 0.
- `complete` output 1: 1 = idle/result valid, 0 = busy; reset value 1.
- `overflow` output 1: 1 = last result saturated; reset value 0; valid with `complete`.

## Operation
- States: IDLE (`complete`=1) and BUSY (`complete`=0).
- IDLE with `start`=1: latch `|A|`, `|B|`, result sign = A[N-1] XOR B[N-1]; clear the 2(N-1)-bit accumulator; load bit counter = N-2; go to BUSY.
- BUSY, each cycle:
  - If the multiplier copy's LSB is 1, add the multiplicand copy (2(N-1) bits wide) to the accumulator.
  - Shift the multiplicand copy left 1 and the multiplier copy right 1.
  - Decrement the counter.
  - The cycle that processes counter = 0 also registers the result and returns to IDLE.
- Result formation, from the final accumulator value, including that cycle's add:
  - Magnitude = acc[N-2+Q : Q]. This truncates; there is no rounding.
  - If any of acc[2(N-1)-1 : N-1+Q] is nonzero, magnitude = all ones and `overflow`=1; otherwise `overflow`=0.
  - If the final magnitude is 0, the sign bit is forced to 0. Negative zero is never output.
- `start` while BUSY is ignored. There is no queueing and the operands are not re-sampled.
- `product_out`/`overflow` hold their last value until the next completion. `start` does not clear them.
- `reset` in any state:
  - Go to IDLE, abort any operation in progress.
  - `product_out`=0, `complete`=1, `overflow`=0.
  - `start` on the same edge as `reset` is ignored.

## Timing
- Accepting edge k: `complete` falls after edge k.
- BUSY lasts exactly N-1 cycles. Edges k+1 … k+N-1 process multiplier bits 0 … N-2.
- After edge k+N-1: `complete`=1, with `product_out` and `overflow` updated on that same edge.
- Latency: N-1 cycles from acceptance to result (31 cycles at the default N).
- Back-to-back: `start` held high at edge k+N-1 is not accepted, because `complete` was 0 before that edge. The earliest next acceptance is edge k+N. Throughput is one result per N cycles.

## Structure
- Shared package `qmath_pkg`:
  - default `N`/`Q` constants,
  - state enum {IDLE, BUSY},
  - localparam accumulator width 2(N-1),
  - counter width $clog2(N).
- The divider uses the same package.
- Single module, no sub-module. The datapath is one adder plus shifters, and a separate controller would be thinner than its interface.

## Test plan
All values use N=32, Q=15; 1.0 = 0x00008000.
- 0x0000C000 × 0x00010000 (1.5×2.0) → `product_out`=0x00018000, `overflow`=0; `complete` low for exactly 31 cycles.
- 0x8000C000 × 0x00010000 (−1.5×2.0) → 0x80018000. 0x8000C000 × 0x8000C000 (−1.5×−1.5) → 0x00012000.
- 0x00004000 × 0x00004000 (0.5×0.5) → 0x00002000. 0x80000001 × 0x00000001 → truncates to 0x00000000 (sign cleared).
- 0x40000000 × 0x00010000 → `product_out`=0x7FFFFFFF, `overflow`=1. The following 0x00008000 × 0x00008000 → 0x00008000, `overflow`=0.
- `start` pulsed with new operands mid-operation → ignored, first result unchanged. `start` held high continuously → a new acceptance every 32 cycles.
- `reset` asserted at BUSY cycle 10 → next cycle `complete`=1, `product_out`=0, `overflow`=0. A fresh 1.0×1.0 then yields 0x00008000 after 31 cycles.
